// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid buffer: the occupancy-coded state encoding.
package skid_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/dfflr.sv
// Common library flop: async active-low reset to zero, load when en_i is high.
module dfflr #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/dffrc.sv
// Common library flop: async active-low reset to a configurable constant, loads every cycle.
module dffrc #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= RESET_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice; every output comes straight from a flop or the state decode.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_dat_o,
    output logic [1:0]            cnt_o
);

    skid_state_e           state_q;
    skid_state_e           state_d;
    logic [1:0]            state_raw;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  main_en;
    logic                  main_from_skid;
    logic                  skid_en;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;

    assign state_q  = skid_state_e'(state_raw);
    assign in_xfer  = s_valid_i & s_ready_o;
    assign out_xfer = m_valid_o & m_ready_i;

    // Handshake outputs depend on the state register alone, which is what breaks the ready path.
    always_comb begin
        s_ready_o = 1'b1;
        m_valid_o = 1'b0;
        cnt_o     = 2'd0;
        case (state_q)
            EMPTY: begin
                s_ready_o = 1'b1;
                m_valid_o = 1'b0;
                cnt_o     = 2'd0;
            end
            BUSY: begin
                s_ready_o = 1'b1;
                m_valid_o = 1'b1;
                cnt_o     = 2'd1;
            end
            FULL: begin
                s_ready_o = 1'b0;
                m_valid_o = 1'b1;
                cnt_o     = 2'd2;
            end
            default: begin
                s_ready_o = 1'b0;
                m_valid_o = 1'b0;
                cnt_o     = 2'd0;
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // The older beat leaves; the stalled one moves up from the skid slot.
                if (out_xfer) begin
                    state_d        = BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign main_d = main_from_skid ? skid_q : s_dat_i;

    dffrc #(
        .WIDTH     (2),
        .RESET_VAL (EMPTY)
    ) u_state (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (state_d),
        .q_o     (state_raw)
    );

    dfflr #(
        .WIDTH (DATA_WIDTH)
    ) u_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (main_en),
        .d_i     (main_d),
        .q_o     (m_dat_o)
    );

    dfflr #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (skid_en),
        .d_i     (s_dat_i),
        .q_o     (skid_q)
    );

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and randomized bench for skid_buffer with an occupancy/queue reference model.
module tb_skid_buffer;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] s_dat_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [DW-1:0] m_dat_o;
    logic [1:0]    cnt_o;

    int errors = 0;
    int checks = 0;

    skid_buffer #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_dat_i   (s_dat_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_dat_o   (m_dat_o),
        .cnt_o     (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] dat, input logic ready);
        s_valid_i = valid;
        s_dat_i   = dat;
        m_ready_i = ready;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(s_ready_o), 32'd1);
        checkOutput({tag, "_m_valid"}, 32'(m_valid_o), 32'd0);
        checkOutput({tag, "_cnt"},     32'(cnt_o),     32'd0);
    endtask

    logic [DW-1:0] sb_q[$];
    int            model_cnt;
    logic          in_x;
    logic          out_x;
    int            delivered;
    int            accepted;

    initial begin
        rst_n_i = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        checkIdle("reset_held");
        checkOutput("reset_held_m_dat", m_dat_o, 32'h0);
        #21;
        rst_n_i = 1'b1;
        stepCycle();
        stepCycle();
        checkIdle("reset_idle");
        checkOutput("reset_idle_m_dat", m_dat_o, 32'h0);

        // Back-to-back stream with the sink always ready.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b1);
            stepCycle();
            checkOutput($sformatf("stream_dat_%0d", i), m_dat_o, 32'(i));
            checkOutput($sformatf("stream_valid_%0d", i), 32'(m_valid_o), 32'd1);
            checkOutput($sformatf("stream_cnt_%0d", i), 32'(cnt_o), 32'd1);
            checkOutput($sformatf("stream_ready_%0d", i), 32'(s_ready_o), 32'd1);
        end
        applyStimulus(1'b0, '0, 1'b1);
        stepCycle();
        checkIdle("stream_drained");

        // Stall: A lands in main, B in skid, C must be refused.
        applyStimulus(1'b1, 32'hA, 1'b0);
        stepCycle();
        checkOutput("stall_a_dat", m_dat_o, 32'hA);
        checkOutput("stall_a_cnt", 32'(cnt_o), 32'd1);
        checkOutput("stall_a_ready", 32'(s_ready_o), 32'd1);
        applyStimulus(1'b1, 32'hB, 1'b0);
        stepCycle();
        checkOutput("stall_b_dat", m_dat_o, 32'hA);
        checkOutput("stall_b_cnt", 32'(cnt_o), 32'd2);
        checkOutput("stall_b_ready", 32'(s_ready_o), 32'd0);
        applyStimulus(1'b1, 32'hC, 1'b0);
        stepCycle();
        checkOutput("stall_c_dat", m_dat_o, 32'hA);
        checkOutput("stall_c_cnt", 32'(cnt_o), 32'd2);
        applyStimulus(1'b0, '0, 1'b1);
        stepCycle();
        checkOutput("release_b_dat", m_dat_o, 32'hB);
        checkOutput("release_b_valid", 32'(m_valid_o), 32'd1);
        checkOutput("release_b_cnt", 32'(cnt_o), 32'd1);
        checkOutput("release_b_ready", 32'(s_ready_o), 32'd1);
        stepCycle();
        checkIdle("release_done");

        // Random traffic against an independent occupancy and FIFO model.
        model_cnt = 0;
        accepted  = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checkOutput("rand_cnt",     32'(cnt_o),     32'(model_cnt));
            checkOutput("rand_s_ready", 32'(s_ready_o), 32'(model_cnt < 2));
            checkOutput("rand_m_valid", 32'(m_valid_o), 32'(model_cnt > 0));
            if (model_cnt > 0) begin
                checkOutput("rand_m_dat", m_dat_o, sb_q[0]);
            end
            applyStimulus(1'($urandom_range(1)), DW'($urandom), 1'($urandom_range(1)));
            in_x  = s_valid_i && (model_cnt < 2);
            out_x = m_ready_i && (model_cnt > 0);
            stepCycle();
            if (out_x) begin
                void'(sb_q.pop_front());
                model_cnt--;
                delivered++;
            end
            if (in_x) begin
                sb_q.push_back(s_dat_i);
                model_cnt++;
                accepted++;
            end
        end
        for (int k = 0; k < 4 && model_cnt > 0; k++) begin
            checkOutput("drain_dat", m_dat_o, sb_q[0]);
            applyStimulus(1'b0, '0, 1'b1);
            stepCycle();
            void'(sb_q.pop_front());
            model_cnt--;
            delivered++;
        end
        checkOutput("drain_empty_model", 32'(model_cnt), 32'd0);
        checkOutput("rand_lossless", 32'(delivered), 32'(accepted));
        checkIdle("rand_drained");

        // Fill with 5/6, then reset mid-cycle and confirm nothing survives.
        applyStimulus(1'b1, 32'h5, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h6, 1'b0);
        stepCycle();
        checkOutput("pre_reset_cnt", 32'(cnt_o), 32'd2);
        checkOutput("pre_reset_dat", m_dat_o, 32'h5);
        applyStimulus(1'b0, '0, 1'b0);
        #2;
        rst_n_i = 1'b0;
        #1;
        checkIdle("async_reset");
        checkOutput("async_reset_m_dat", m_dat_o, 32'h0);
        #3;
        rst_n_i = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            checkIdle($sformatf("post_reset_%0d", k));
        end
        applyStimulus(1'b1, 32'h77, 1'b1);
        stepCycle();
        checkOutput("post_reset_fresh_dat", m_dat_o, 32'h77);
        checkOutput("post_reset_fresh_cnt", 32'(cnt_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
